// File: rtl/truth_table_checker_if.sv
// Bundle of the start/done handshake, the DUT stimulus/response pair and the result bus
// for truth_table_checker. The slave modport is the checker's view; the master modport is the controller/DUT side.
interface truth_table_checker_if #(
  parameter int N_IN = 4
) ();
  logic                   start;
  logic                   f_in;
  logic [N_IN-1:0]        vec_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(1<<N_IN)-1:0]   captured;
  logic [N_IN:0]          mismatch_count;
  logic [N_IN-1:0]        first_fail_idx;
  logic                   fail_valid;

  modport master (
    output start, f_in,
    input  vec_out, busy, done, pass, captured, mismatch_count, first_fail_idx, fail_valid
  );

  modport slave (
    input  start, f_in,
    output vec_out, busy, done, pass, captured, mismatch_count, first_fail_idx, fail_valid
  );
endinterface

// File: rtl/truth_table_checker.sv
// Sequential exhaustive checker: steps an N_IN-input combinational DUT through every vector,
// samples its single output after HOLD cycles and compares the captured truth table to EXPECTED.
module truth_table_checker #(
  parameter int                    N_IN     = 4,
  parameter int                    HOLD     = 20,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = 16'hFF00
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_checker_if.slave  chk_if
);
  localparam int T  = 1 << N_IN;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   MC_ONE    = (N_IN+1)'(1);

  logic [1:0]      state_q,    state_d;
  logic [N_IN-1:0] idx_q,      idx_d;
  logic [HW-1:0]   hold_q,     hold_d;
  logic [T-1:0]    captured_q, captured_d;
  logic [N_IN:0]   mism_q,     mism_d;
  logic [N_IN-1:0] ffi_q,      ffi_d;
  logic            fv_q,       fv_d;
  logic            pass_q,     pass_d;
  logic            done_q,     done_d;
  logic            busy_q,     busy_d;

  // Next-state logic for the run sequencer and the result accumulators.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    captured_d = captured_q;
    mism_d     = mism_q;
    ffi_d      = ffi_q;
    fv_d       = fv_q;
    pass_d     = pass_q;
    done_d     = done_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (chk_if.start) begin
          state_d    = S_DRIVE;
          idx_d      = {N_IN{1'b0}};
          hold_d     = {HW{1'b0}};
          captured_d = {T{1'b0}};
          mism_d     = {(N_IN+1){1'b0}};
          ffi_d      = {N_IN{1'b0}};
          fv_d       = 1'b0;
          pass_d     = 1'b0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          captured_d[idx_q] = chk_if.f_in;
          if (chk_if.f_in != EXPECTED[idx_q]) begin
            mism_d = mism_q + MC_ONE;
            if (!fv_q) begin
              ffi_d = idx_q;
              fv_d  = 1'b1;
            end else begin
              ffi_d = ffi_q;
            end
          end else begin
            mism_d = mism_q;
          end
          // pass must reflect the compare made on this same final sample edge.
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mism_d == {(N_IN+1){1'b0}});
          end else begin
            idx_d  = idx_q + IDX_ONE;
            hold_d = {HW{1'b0}};
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= {N_IN{1'b0}};
      hold_q     <= {HW{1'b0}};
      captured_q <= {T{1'b0}};
      mism_q     <= {(N_IN+1){1'b0}};
      ffi_q      <= {N_IN{1'b0}};
      fv_q       <= 1'b0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      captured_q <= captured_d;
      mism_q     <= mism_d;
      ffi_q      <= ffi_d;
      fv_q       <= fv_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // idx_q is 0 in IDLE and parks at T-1 in DONE, so it doubles as the driven vector.
  assign chk_if.vec_out        = idx_q;
  assign chk_if.busy           = busy_q;
  assign chk_if.done           = done_q;
  assign chk_if.pass           = pass_q;
  assign chk_if.captured       = captured_q;
  assign chk_if.mismatch_count = mism_q;
  assign chk_if.first_fail_idx = ffi_q;
  assign chk_if.fail_valid     = fv_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// Directed self-checking bench: loopback DUTs built from vec_out bits, HOLD=20 and HOLD=1 instances.
module tb_truth_table_checker;
  localparam int HOLD = 20;

  logic clk;
  logic rst;
  logic sel_lsb;
  int   checks_cnt;
  int   errors_cnt;

  truth_table_checker_if #(.N_IN(4)) if20 ();
  truth_table_checker_if #(.N_IN(4)) if1 ();

  truth_table_checker #(.N_IN(4), .HOLD(HOLD), .EXPECTED(16'hFF00)) dut20 (
    .clk(clk), .rst(rst), .chk_if(if20)
  );
  truth_table_checker #(.N_IN(4), .HOLD(1), .EXPECTED(16'hFF00)) dut1 (
    .clk(clk), .rst(rst), .chk_if(if1)
  );

  assign if20.f_in = sel_lsb ? if20.vec_out[0] : if20.vec_out[3];
  assign if1.f_in  = if1.vec_out[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".vec_out"},   32'(if20.vec_out), 32'd0);
    check_eq({tag, ".busy"},      32'(if20.busy), 32'd0);
    check_eq({tag, ".done"},      32'(if20.done), 32'd0);
    check_eq({tag, ".pass"},      32'(if20.pass), 32'd0);
    check_eq({tag, ".captured"},  32'(if20.captured), 32'd0);
    check_eq({tag, ".mismatch"},  32'(if20.mismatch_count), 32'd0);
    check_eq({tag, ".first_idx"}, 32'(if20.first_fail_idx), 32'd0);
    check_eq({tag, ".fail_valid"},32'(if20.fail_valid), 32'd0);
  endtask

  // One complete run on the HOLD=20 instance, optionally pulsing start at vector 5.
  task automatic run_check(input string tag, input logic sel, input logic pulse5,
                           input logic [15:0] ecap, input int emis, input int effi,
                           input logic efv, input logic epass);
    sel_lsb = sel;
    if20.start = 1'b1;
    tick(1);
    if20.start = 1'b0;
    check_eq({tag, ".start_busy"},     32'(if20.busy), 32'd1);
    check_eq({tag, ".start_done"},     32'(if20.done), 32'd0);
    check_eq({tag, ".start_pass"},     32'(if20.pass), 32'd0);
    check_eq({tag, ".start_captured"}, 32'(if20.captured), 32'd0);
    check_eq({tag, ".start_mismatch"}, 32'(if20.mismatch_count), 32'd0);
    check_eq({tag, ".start_fv"},       32'(if20.fail_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check_eq({tag, ".vec"},  32'(if20.vec_out), 32'(i));
      check_eq({tag, ".busy"}, 32'(if20.busy), 32'd1);
      if (pulse5 && i == 5) begin
        if20.start = 1'b1;
        tick(1);
        if20.start = 1'b0;
        check_eq({tag, ".vec_after_pulse"}, 32'(if20.vec_out), 32'd5);
        tick(HOLD - 1);
      end else begin
        tick(HOLD - 1);
        check_eq({tag, ".done_early"}, 32'(if20.done), 32'd0);
        tick(1);
      end
    end
    check_eq({tag, ".done"},       32'(if20.done), 32'd1);
    check_eq({tag, ".busy_end"},   32'(if20.busy), 32'd0);
    check_eq({tag, ".vec_end"},    32'(if20.vec_out), 32'd15);
    check_eq({tag, ".captured"},   32'(if20.captured), 32'(ecap));
    check_eq({tag, ".mismatch"},   32'(if20.mismatch_count), 32'(emis));
    check_eq({tag, ".first_idx"},  32'(if20.first_fail_idx), 32'(effi));
    check_eq({tag, ".fail_valid"}, 32'(if20.fail_valid), 32'(efv));
    check_eq({tag, ".pass"},       32'(if20.pass), 32'(epass));
    tick(3);
    check_eq({tag, ".hold_done"},     32'(if20.done), 32'd1);
    check_eq({tag, ".hold_captured"}, 32'(if20.captured), 32'(ecap));
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst        = 1'b1;
    sel_lsb    = 1'b0;
    if20.start = 1'b0;
    if1.start  = 1'b0;
    #2;
    check_all_zero("reset_noclk");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(10);
    check_all_zero("idle10");

    run_check("pass_pulse5", 1'b0, 1'b1, 16'hFF00, 0, 0, 1'b0, 1'b1);
    run_check("fail_lsb",    1'b1, 1'b0, 16'hAAAA, 8, 1, 1'b1, 1'b0);

    // Abort a run while vector 7 is being driven.
    sel_lsb = 1'b0;
    if20.start = 1'b1;
    tick(1);
    if20.start = 1'b0;
    tick(7 * HOLD);
    check_eq("midrst.vec7", 32'(if20.vec_out), 32'd7);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    #1;
    rst = 1'b0;
    tick(2);
    check_all_zero("midrst_idle");
    run_check("pass_after_rst", 1'b0, 1'b0, 16'hFF00, 0, 0, 1'b0, 1'b1);

    // start held high from DONE: done must be high for exactly one cycle between runs.
    if20.start = 1'b1;
    tick(1);
    check_eq("held.busy",     32'(if20.busy), 32'd1);
    check_eq("held.done_clr", 32'(if20.done), 32'd0);
    check_eq("held.cap_clr",  32'(if20.captured), 32'd0);
    tick(16 * HOLD - 1);
    check_eq("held.done_early", 32'(if20.done), 32'd0);
    tick(1);
    check_eq("held.done",     32'(if20.done), 32'd1);
    check_eq("held.pass",     32'(if20.pass), 32'd1);
    tick(1);
    check_eq("held.done_1cyc", 32'(if20.done), 32'd0);
    check_eq("held.rebusy",    32'(if20.busy), 32'd1);
    check_eq("held.revec",     32'(if20.vec_out), 32'd0);
    if20.start = 1'b0;
    tick(16 * HOLD);
    check_eq("held.done2",     32'(if20.done), 32'd1);
    check_eq("held.captured2", 32'(if20.captured), 32'hFF00);

    // Minimum hold instance.
    if1.start = 1'b1;
    tick(1);
    if1.start = 1'b0;
    check_eq("h1.busy", 32'(if1.busy), 32'd1);
    check_eq("h1.vec0", 32'(if1.vec_out), 32'd0);
    tick(3);
    check_eq("h1.vec3", 32'(if1.vec_out), 32'd3);
    tick(12);
    check_eq("h1.done_early", 32'(if1.done), 32'd0);
    tick(1);
    check_eq("h1.done",     32'(if1.done), 32'd1);
    check_eq("h1.captured", 32'(if1.captured), 32'hFF00);
    check_eq("h1.mismatch", 32'(if1.mismatch_count), 32'd0);
    check_eq("h1.pass",     32'(if1.pass), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
